// File: rtl/sysid_reader_pkg.sv
// Shared state encoding and Avalon word addresses for the system-ID reader.
// Imported by sysid_reader and its watchdog sub-module.
package sysid_reader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_reader_wdog.sv
// Stall watchdog: counts consecutive waitrequest-stalled read cycles.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th stall cycle.
// Backpressure: none; clear has priority over enable.
module sysid_reader_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] stall_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 16'd0;
        end else if (clear) begin
            stall_cnt <= 16'd0;
        end else if (enable) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign expired = enable && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sysid_reader.sv
// Reads the ID and timestamp words over Avalon-MM and compares them to expected values.
// Latency: start -> done in 3 cycles plus stalls and 2*READ_LATENCY; outputs decode registered state.
// Backpressure: read/address held while waitrequest=1; SYSID_READER_TIMEOUT_EN adds a stall timeout.
module sysid_reader
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1417920494,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        read,
    output logic        address,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err
);

    localparam bit         LAT0  = (READ_LATENCY == 0);
    localparam logic [1:0] LAT_N = 2'(READ_LATENCY);

    state_t     state, state_nxt;
    logic       accept, lat_hit, cap_id, cap_ts, wd_expired;
    logic [1:0] lat_cnt;

    assign read    = (state == RD_ID) || (state == RD_TS);
    assign address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign accept  = read && !waitrequest;
    assign lat_hit = (lat_cnt == LAT_N);

    always_comb begin
        state_nxt = state;
        cap_id    = 1'b0;
        cap_ts    = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RD_ID;
            RD_ID: begin
                if (wd_expired) begin
                    state_nxt = FIN;
                end else if (accept) begin
                    cap_id    = LAT0;
                    state_nxt = LAT0 ? RD_TS : LAT_ID;
                end
            end
            LAT_ID: if (lat_hit) begin
                cap_id    = 1'b1;
                state_nxt = RD_TS;
            end
            RD_TS: begin
                if (wd_expired) begin
                    state_nxt = FIN;
                end else if (accept) begin
                    cap_ts    = LAT0;
                    state_nxt = LAT0 ? FIN : LAT_TS;
                end
            end
            LAT_TS: if (lat_hit) begin
                cap_ts    = 1'b1;
                state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // lat_cnt holds the number of cycles elapsed since the read was accepted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt <= 2'd0;
        end else if (accept) begin
            lat_cnt <= 2'd1;
        end else if ((state == LAT_ID) || (state == LAT_TS)) begin
            lat_cnt <= lat_cnt + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= 32'd0;
            ts_value <= 32'd0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
        end else begin
            if (cap_id) begin
                id_value <= readdata;
                id_match <= (readdata == EXPECTED_ID);
            end
            if (cap_ts) begin
                ts_value <= readdata;
                ts_match <= (readdata == EXPECTED_TS);
            end
        end
    end

`ifdef SYSID_READER_TIMEOUT_EN
    logic stall;
    logic te_q;

    assign stall = read && waitrequest;

    sysid_reader_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!stall),
        .enable  (stall),
        .expired (wd_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            te_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            te_q <= 1'b0;
        end else if (wd_expired) begin
            te_q <= 1'b1;
        end
    end

    assign timeout_err = te_q;
`else
    // Without the watchdog a stalled read waits forever
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_reader.sv
// Bench: two readers (latency 0 and 2) share one stimulus trace; a trace-walking
// model predicts every output cycle by cycle.
module tb_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1417920494;
    localparam int          TO     = 4;
    localparam int          NC     = 400;
`ifdef SYSID_READER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'd0;

    logic        o_read [2], o_addr [2], o_busy [2], o_done [2], o_idm [2], o_tsm [2], o_te [2];
    logic [31:0] o_id [2], o_ts [2];

    // stimulus trace and per-DUT expected outputs
    logic        s_start [NC];
    logic        s_wr    [NC];
    logic [31:0] s_rd    [NC];
    logic        e_read [2][NC], e_addr [2][NC], e_busy [2][NC], e_done [2][NC];
    logic        e_idm  [2][NC], e_tsm  [2][NC], e_te   [2][NC];
    logic [31:0] e_id   [2][NC], e_ts   [2][NC];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    sysid_reader #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0), .TIMEOUT_CYCLES(TO)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .read(o_read[0]), .address(o_addr[0]),
        .waitrequest(waitrequest), .readdata(readdata), .busy(o_busy[0]), .done(o_done[0]),
        .id_value(o_id[0]), .ts_value(o_ts[0]), .id_match(o_idm[0]), .ts_match(o_tsm[0]),
        .timeout_err(o_te[0])
    );

    sysid_reader #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2), .TIMEOUT_CYCLES(TO)
    ) dut2 (
        .clock(clock), .reset_n(reset_n), .start(start), .read(o_read[1]), .address(o_addr[1]),
        .waitrequest(waitrequest), .readdata(readdata), .busy(o_busy[1]), .done(o_done[1]),
        .id_value(o_id[1]), .ts_value(o_ts[1]), .id_match(o_idm[1]), .ts_match(o_tsm[1]),
        .timeout_err(o_te[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input int d, input int c, input logic rd, input logic ad, input logic bz,
                       input logic dn, input logic [31:0] iv, input logic [31:0] tv,
                       input logic im, input logic tm, input logic te);
        if (c < NC) begin
            e_read[d][c] = rd; e_addr[d][c] = ad; e_busy[d][c] = bz; e_done[d][c] = dn;
            e_id[d][c] = iv; e_ts[d][c] = tv; e_idm[d][c] = im; e_tsm[d][c] = tm; e_te[d][c] = te;
        end
    endtask

    // Walk the trace: each accepted start yields two reads, each finishing at the first
    // non-stalled cycle (or timing out), captured lat cycles later, then one done cycle.
    task automatic build_model(input int d, input int lat);
        logic [31:0] idv, tsv;
        logic        idm, tsm, te;
        int          c, p, stall, k;
        bit          to_hit;
        idv = 0; tsv = 0; idm = 0; tsm = 0; te = 0;
        c = 0;
        while (c < NC) begin
            put(d, c, 0, 0, 0, 0, idv, tsv, idm, tsm, te);
            if (s_start[c]) begin
                te = 0;
                p = c + 1;
                to_hit = 0;
                for (int a = 0; a < 2 && !to_hit && p < NC; a++) begin
                    stall = 0;
                    while (p < NC) begin
                        put(d, p, 1, (a == 1), 1, 0, idv, tsv, idm, tsm, te);
                        if (!s_wr[p]) break;
                        stall++;
                        if (TO_EN && stall == TO) begin
                            te = 1;
                            to_hit = 1;
                        end
                        p++;
                        if (to_hit) break;
                    end
                    if (!to_hit && p < NC) begin
                        k = p + lat;
                        for (int q = p + 1; q <= k; q++) put(d, q, 0, 0, 1, 0, idv, tsv, idm, tsm, te);
                        if (k < NC) begin
                            if (a == 0) begin idv = s_rd[k]; idm = (s_rd[k] == EXP_ID); end
                            else        begin tsv = s_rd[k]; tsm = (s_rd[k] == EXP_TS); end
                        end
                        p = k + 1;
                    end
                end
                put(d, p, 0, 0, 1, 1, idv, tsv, idm, tsm, te);
                c = p + 1;
            end else begin
                c++;
            end
        end
    endtask

    task automatic cmp(input int d);
        string t;
        t = $sformatf("d%0d_c%0d", d, cyc);
        chk({t, "_read"}, 32'(o_read[d]), 32'(e_read[d][cyc]));
        chk({t, "_address"}, 32'(o_addr[d]), 32'(e_addr[d][cyc]));
        chk({t, "_busy"}, 32'(o_busy[d]), 32'(e_busy[d][cyc]));
        chk({t, "_done"}, 32'(o_done[d]), 32'(e_done[d][cyc]));
        chk({t, "_id_value"}, o_id[d], e_id[d][cyc]);
        chk({t, "_ts_value"}, o_ts[d], e_ts[d][cyc]);
        chk({t, "_id_match"}, 32'(o_idm[d]), 32'(e_idm[d][cyc]));
        chk({t, "_ts_match"}, 32'(o_tsm[d]), 32'(e_tsm[d][cyc]));
        chk({t, "_timeout_err"}, 32'(o_te[d]), 32'(e_te[d][cyc]));
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            cmp(0);
            cmp(1);
        end
    end

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_read", tag, d), 32'(o_read[d]), 32'd0);
            chk($sformatf("%s_d%0d_address", tag, d), 32'(o_addr[d]), 32'd0);
            chk($sformatf("%s_d%0d_busy", tag, d), 32'(o_busy[d]), 32'd0);
            chk($sformatf("%s_d%0d_done", tag, d), 32'(o_done[d]), 32'd0);
            chk($sformatf("%s_d%0d_id_value", tag, d), o_id[d], 32'd0);
            chk($sformatf("%s_d%0d_ts_value", tag, d), o_ts[d], 32'd0);
            chk($sformatf("%s_d%0d_id_match", tag, d), 32'(o_idm[d]), 32'd0);
            chk($sformatf("%s_d%0d_ts_match", tag, d), 32'(o_tsm[d]), 32'd0);
            chk($sformatf("%s_d%0d_timeout_err", tag, d), 32'(o_te[d]), 32'd0);
        end
    endtask

    task automatic do_reset();
        chk_en = 0;
        reset_n = 0; start = 0; waitrequest = 0; readdata = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
    endtask

    task automatic clear_trace();
        for (int c = 0; c < NC; c++) begin
            s_start[c] = 0; s_wr[c] = 0; s_rd[c] = $urandom;
        end
    endtask

    task automatic gen_trace(input int wr_pct, input int st_pct);
        int r;
        for (int c = 0; c < NC; c++) begin
            s_start[c] = (c < NC - 40) && (int'($urandom_range(99)) < st_pct);
            s_wr[c]    = (c < NC - 30) && (int'($urandom_range(99)) < wr_pct);
            r = int'($urandom_range(3));
            s_rd[c]    = (r == 0) ? EXP_ID : (r == 1) ? EXP_TS : $urandom;
        end
    endtask

    task automatic run_trace(input int upto);
        build_model(0, 0);
        build_model(1, 2);
        for (int c = 0; c < upto; c++) begin
            start = s_start[c]; waitrequest = s_wr[c]; readdata = s_rd[c];
            cyc = c;
            chk_en = 1;
            @(posedge clock);
            #1;
        end
        chk_en = 0;
        start = 0;
    endtask

    int n_done;

    initial begin
        @(posedge clock);
        #1 check_zero("in_reset");
        do_reset();

        // latency 0, clean slave; second start while busy must be ignored
        clear_trace();
        s_start[0] = 1; s_start[2] = 1; s_rd[1] = 32'd0; s_rd[2] = EXP_TS;
        build_model(0, 0);
        chk("pin_a_read_c1", 32'(e_read[0][1]), 32'd1);
        chk("pin_a_addr_c1", 32'(e_addr[0][1]), 32'd0);
        chk("pin_a_read_c2", 32'(e_read[0][2]), 32'd1);
        chk("pin_a_addr_c2", 32'(e_addr[0][2]), 32'd1);
        chk("pin_a_done_c3", 32'(e_done[0][3]), 32'd1);
        chk("pin_a_idm_c4", 32'(e_idm[0][4]), 32'd1);
        chk("pin_a_tsm_c4", 32'(e_tsm[0][4]), 32'd1);
        n_done = 0;
        for (int c = 0; c < NC; c++) n_done += int'(e_done[0][c]);
        chk("pin_a_one_done", n_done, 32'd1);
        run_trace(NC);

        // latency 2 with three stall cycles per read, wrong ID; reset during RD_TS
        do_reset();
        clear_trace();
        for (int c = 0; c < NC; c++) s_rd[c] = EXP_TS;
        s_start[0] = 1; s_rd[6] = 32'h12345678;
        for (int c = 1; c <= 3; c++) s_wr[c] = 1;
        for (int c = 7; c <= 9; c++) s_wr[c] = 1;
        build_model(1, 2);
        chk("pin_b_read_c1", 32'(e_read[1][1]), 32'd1);
        chk("pin_b_read_c4", 32'(e_read[1][4]), 32'd1);
        chk("pin_b_read_c5", 32'(e_read[1][5]), 32'd0);
        chk("pin_b_addr_c10", 32'(e_addr[1][10]), 32'd1);
        chk("pin_b_read_c11", 32'(e_read[1][11]), 32'd0);
        chk("pin_b_done_c12", 32'(e_done[1][12]), 32'd0);
        chk("pin_b_done_c13", 32'(e_done[1][13]), 32'd1);
        chk("pin_b_id_c14", e_id[1][14], 32'h12345678);
        chk("pin_b_idm_c14", 32'(e_idm[1][14]), 32'd0);
        chk("pin_b_tsm_c14", 32'(e_tsm[1][14]), 32'd1);
        run_trace(10);
        #2 reset_n = 0;
        #1 check_zero("reset_mid_read");
        @(posedge clock);
        #1 reset_n = 1;
        for (int i = 0; i < 20; i++) begin
            waitrequest = $urandom_range(1);
            readdata = $urandom;
            @(negedge clock);
            check_zero($sformatf("post_reset_%0d", i));
            @(posedge clock);
            #1;
        end

        // waitrequest stuck high, then a second start
        do_reset();
        clear_trace();
        s_start[0] = 1; s_start[8] = 1;
        for (int c = 0; c <= 6; c++) s_wr[c] = 1;
        build_model(0, 0);
        if (TO_EN) begin
            chk("pin_c_read_c4", 32'(e_read[0][4]), 32'd1);
            chk("pin_c_read_c5", 32'(e_read[0][5]), 32'd0);
            chk("pin_c_done_c5", 32'(e_done[0][5]), 32'd1);
            chk("pin_c_te_c5", 32'(e_te[0][5]), 32'd1);
            chk("pin_c_te_c8", 32'(e_te[0][8]), 32'd1);
            chk("pin_c_te_c9", 32'(e_te[0][9]), 32'd0);
        end else begin
            chk("pin_c_read_c6", 32'(e_read[0][6]), 32'd1);
            chk("pin_c_done_c9", 32'(e_done[0][9]), 32'd1);
            chk("pin_c_te_c9", 32'(e_te[0][9]), 32'd0);
        end
        run_trace(NC);

        // randomized traces with varying stall density
        for (int t = 0; t < 6; t++) begin
            do_reset();
            gen_trace(t * 15, 20);
            run_trace(NC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
